// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO with independent write/read widths, backed by R external
// MINDATA_W-wide two-port RAM banks with 1-cycle synchronous read.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 4,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int R         = MAXDATA_W / MINDATA_W,
  localparam int LOG2R     = $clog2(R),
  localparam int MINADDR_W = ADDR_W - LOG2R,
  localparam int W_ADDR_W  = (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
  localparam int R_ADDR_W  = (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      rst_i,
  input  logic                      w_en_i,
  input  logic [W_DATA_W-1:0]       w_data_i,
  output logic                      w_full_o,
  input  logic                      r_en_i,
  output logic [R_DATA_W-1:0]       r_data_o,
  output logic                      r_empty_o,
  output logic [ADDR_W:0]           level_o,
  output logic [R-1:0]              ext_mem_w_en_o,
  output logic [MINADDR_W*R-1:0]    ext_mem_w_addr_o,
  output logic [MINDATA_W*R-1:0]    ext_mem_w_data_o,
  output logic                      ext_mem_r_en_o,
  output logic [MINADDR_W*R-1:0]    ext_mem_r_addr_o,
  input  logic [MINDATA_W*R-1:0]    ext_mem_r_data_i
);

  localparam int WINC = W_DATA_W / MINDATA_W;
  localparam int RINC = R_DATA_W / MINDATA_W;
  localparam logic [ADDR_W:0] WINC_L  = (ADDR_W+1)'(WINC);
  localparam logic [ADDR_W:0] RINC_L  = (ADDR_W+1)'(RINC);
  localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'((1 << ADDR_W) - WINC);

  logic [W_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                w_acc, r_acc;

  // Reset of either kind also suppresses RAM enables so nothing leaks out.
  assign w_acc = w_en_i & ~full_q  & ~rst_i & ~arst_i;
  assign r_acc = r_en_i & ~empty_q & ~rst_i & ~arst_i;

  always_comb begin
    level_d = level_q;
    if (w_acc) level_d = level_d + WINC_L;
    if (r_acc) level_d = level_d - RINC_L;
    wptr_d  = w_acc ? wptr_q + W_ADDR_W'(1) : wptr_q;
    rptr_d  = r_acc ? rptr_q + R_ADDR_W'(1) : rptr_q;
    full_d  = level_d > FULL_TH;
    empty_d = level_d < RINC_L;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign w_full_o       = full_q;
  assign r_empty_o      = empty_q;
  assign level_o        = level_q;
  assign ext_mem_r_en_o = r_acc;

  if (W_DATA_W < R_DATA_W) begin : g_wnarrow
    // Narrow writes scatter round-robin across banks; wide reads gather a row.
    logic [LOG2R-1:0]     wbank;
    logic [MINADDR_W-1:0] wrow;
    assign wbank = wptr_q[LOG2R-1:0];
    assign wrow  = wptr_q[ADDR_W-1:LOG2R];
    for (genvar p = 0; p < R; p++) begin : g_bank
      assign ext_mem_w_en_o[p]                                = w_acc & (wbank == LOG2R'(p));
      assign ext_mem_w_addr_o[p*MINADDR_W +: MINADDR_W]       = wrow;
      assign ext_mem_w_data_o[p*MINDATA_W +: MINDATA_W]       = w_data_i;
      assign ext_mem_r_addr_o[p*MINADDR_W +: MINADDR_W]       = rptr_q;
    end
    assign r_data_o = ext_mem_r_data_i;
  end else if (W_DATA_W > R_DATA_W) begin : g_rnarrow
    // Wide writes fill a whole row; the lane register picks the narrow word
    // out of the row the RAM returns one cycle later.
    logic [LOG2R-1:0] lane_q;
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)     lane_q <= '0;
      else if (rst_i) lane_q <= '0;
      else if (r_acc) lane_q <= rptr_q[LOG2R-1:0];
    end
    for (genvar p = 0; p < R; p++) begin : g_bank
      assign ext_mem_w_en_o[p]                                = w_acc;
      assign ext_mem_w_addr_o[p*MINADDR_W +: MINADDR_W]       = wptr_q;
      assign ext_mem_w_data_o[p*MINDATA_W +: MINDATA_W]       = w_data_i[p*MINDATA_W +: MINDATA_W];
      assign ext_mem_r_addr_o[p*MINADDR_W +: MINADDR_W]       = rptr_q[ADDR_W-1:LOG2R];
    end
    assign r_data_o = ext_mem_r_data_i[lane_q*MINDATA_W +: MINDATA_W];
  end else begin : g_equal
    assign ext_mem_w_en_o   = w_acc;
    assign ext_mem_w_addr_o = wptr_q;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_addr_o = rptr_q;
    assign r_data_o         = ext_mem_r_data_i;
  end

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: an 8->32 and a 32->8 instance, each with a
// behavioural bank RAM, checked against byte-queue models every cycle.
module tb_iob_fifo_sync_asym;

  logic clk;
  logic arst, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: write 8, read 32
  logic        a_wen, a_ren, a_full, a_empty, a_mren;
  logic [7:0]  a_wd;
  logic [31:0] a_rd;
  logic [4:0]  a_lvl;
  logic [3:0]  a_mwen;
  logic [7:0]  a_mwaddr, a_mraddr;
  logic [31:0] a_mwdata, a_mrdata;
  // B: write 32, read 8
  logic        b_wen, b_ren, b_full, b_empty, b_mren;
  logic [31:0] b_wd;
  logic [7:0]  b_rd;
  logic [4:0]  b_lvl;
  logic [3:0]  b_mwen;
  logic [7:0]  b_mwaddr, b_mraddr;
  logic [31:0] b_mwdata, b_mrdata;

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_a (
    .clk_i(clk), .arst_i(arst), .rst_i(rst),
    .w_en_i(a_wen), .w_data_i(a_wd), .w_full_o(a_full),
    .r_en_i(a_ren), .r_data_o(a_rd), .r_empty_o(a_empty), .level_o(a_lvl),
    .ext_mem_w_en_o(a_mwen), .ext_mem_w_addr_o(a_mwaddr), .ext_mem_w_data_o(a_mwdata),
    .ext_mem_r_en_o(a_mren), .ext_mem_r_addr_o(a_mraddr), .ext_mem_r_data_i(a_mrdata));

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_b (
    .clk_i(clk), .arst_i(arst), .rst_i(rst),
    .w_en_i(b_wen), .w_data_i(b_wd), .w_full_o(b_full),
    .r_en_i(b_ren), .r_data_o(b_rd), .r_empty_o(b_empty), .level_o(b_lvl),
    .ext_mem_w_en_o(b_mwen), .ext_mem_w_addr_o(b_mwaddr), .ext_mem_w_data_o(b_mwdata),
    .ext_mem_r_en_o(b_mren), .ext_mem_r_addr_o(b_mraddr), .ext_mem_r_data_i(b_mrdata));

  // Four 8-bit banks of four rows each per instance; read data holds when idle.
  logic [7:0] a_mem [4][4];
  logic [7:0] b_mem [4][4];
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (a_mwen[p]) a_mem[p][a_mwaddr[p*2 +: 2]] <= a_mwdata[p*8 +: 8];
      if (a_mren)    a_mrdata[p*8 +: 8] <= a_mem[p][a_mraddr[p*2 +: 2]];
    end
  end
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (b_mwen[p]) b_mem[p][b_mwaddr[p*2 +: 2]] <= b_mwdata[p*8 +: 8];
      if (b_mren)    b_mrdata[p*8 +: 8] <= b_mem[p][b_mraddr[p*2 +: 2]];
    end
  end

  // Model: FIFO contents as a queue of bytes, capacity 16 bytes.
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int          a_wcnt;
  logic [31:0] a_exp;
  logic [7:0]  b_exp;
  bit          a_have, b_have;
  int          n_pass, n_tot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete();
    a_wcnt = 0; a_have = 0; b_have = 0;
  endtask

  task automatic check_state();
    chk("a_level", 32'(a_lvl), qa.size());
    chk("a_full",  32'(a_full),  32'(qa.size() > 15));
    chk("a_empty", 32'(a_empty), 32'(qa.size() < 4));
    if (a_have) chk("a_rdata", a_rd, a_exp);
    chk("b_level", 32'(b_lvl), qb.size());
    chk("b_full",  32'(b_full),  32'(qb.size() > 12));
    chk("b_empty", 32'(b_empty), 32'(qb.size() < 1));
    if (b_have) chk("b_rdata", 32'(b_rd), 32'(b_exp));
  endtask

  // Enter and leave at a falling edge.
  task automatic step(input bit aw, input logic [7:0] awd, input bit ar,
                      input bit bw, input logic [31:0] bwd, input bit br);
    bit a_wacc, a_racc, b_wacc, b_racc;
    a_wen = aw; a_wd = awd; a_ren = ar;
    b_wen = bw; b_wd = bwd; b_ren = br;
    a_wacc = aw && (qa.size() <= 15);
    a_racc = ar && (qa.size() >= 4);
    b_wacc = bw && (qb.size() <= 12);
    b_racc = br && (qb.size() >= 1);
    #1;
    chk("a_mem_wen", 32'(a_mwen), a_wacc ? (32'd1 << (a_wcnt % 4)) : 32'd0);
    chk("a_mem_ren", 32'(a_mren), 32'(a_racc));
    chk("b_mem_wen", 32'(b_mwen), b_wacc ? 32'hF : 32'd0);
    chk("b_mem_ren", 32'(b_mren), 32'(b_racc));
    @(posedge clk);
    if (a_racc) begin
      a_exp = {qa[3], qa[2], qa[1], qa[0]};
      repeat (4) void'(qa.pop_front());
      a_have = 1;
    end
    if (a_wacc) begin qa.push_back(awd); a_wcnt++; end
    if (b_racc) begin b_exp = qb.pop_front(); b_have = 1; end
    if (b_wacc) for (int i = 0; i < 4; i++) qb.push_back(bwd[i*8 +: 8]);
    @(negedge clk);
    a_wen = 0; a_ren = 0; b_wen = 0; b_ren = 0;
    check_state();
  endtask

  task automatic sync_rst();
    a_wen = 0; a_ren = 0; b_wen = 0; b_ren = 0;
    rst = 1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 0;
    check_state();
  endtask

  initial begin
    logic [7:0] cnt;
    n_pass = 0; n_tot = 0;
    arst = 1; rst = 0;
    a_wen = 0; a_ren = 0; a_wd = '0;
    b_wen = 0; b_ren = 0; b_wd = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_a_full",  32'(a_full),  0);
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_level", 32'(a_lvl),   0);
    chk("rst_a_memwen", 32'(a_mwen), 0);
    chk("rst_b_empty", 32'(b_empty), 1);
    chk("rst_b_memren", 32'(b_mren), 0);
    arst = 0;
    @(negedge clk);

    // Narrow-to-wide gather, wide-to-narrow scatter.
    step(1, 8'h11, 0, 1, 32'hDDCCBBAA, 0);
    chk("b_level_lit", 32'(b_lvl), 4);
    step(1, 8'h22, 0, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0, 0);
    chk("a_empty_3", 32'(a_empty), 1);
    step(1, 8'h44, 0, 0, 0, 0);
    chk("a_empty_4", 32'(a_empty), 0);
    chk("a_level_4", 32'(a_lvl), 4);
    step(0, 0, 1, 0, 0, 1);
    chk("a_rdata_lit", a_rd, 32'h44332211);
    chk("a_level_0", 32'(a_lvl), 0);
    chk("b_rd_aa", 32'(b_rd), 32'hAA);
    step(0, 0, 0, 0, 0, 1);
    chk("b_rd_bb", 32'(b_rd), 32'hBB);
    step(0, 0, 0, 0, 0, 1);
    chk("b_rd_cc", 32'(b_rd), 32'hCC);
    step(0, 0, 0, 0, 0, 1);
    chk("b_rd_dd", 32'(b_rd), 32'hDD);
    chk("b_empty_lit", 32'(b_empty), 1);

    // Fill to capacity, then a rejected 17th write.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h50 + i), 0, 0, 0, 0);
    chk("a_full_lit",  32'(a_full), 1);
    chk("a_level_16",  32'(a_lvl), 16);
    step(1, 8'hEE, 0, 0, 0, 0);
    chk("a_level_17w", 32'(a_lvl), 16);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    chk("a_last_word", a_rd, 32'h5F5E5D5C);

    // Simultaneous write and read at level 4.
    step(1, 8'h01, 0, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0, 0);
    step(1, 8'h04, 0, 0, 0, 0);
    step(1, 8'h05, 1, 0, 0, 0);
    chk("a_simul_level", 32'(a_lvl), 1);
    chk("a_simul_rdata", a_rd, 32'h04030201);
    step(0, 0, 0, 1, 32'h12345678, 0);
    sync_rst();
    chk("srst_a_level", 32'(a_lvl), 0);
    chk("srst_b_empty", 32'(b_empty), 1);

    // Three fill/drain passes with an incrementing pattern across pointer wrap.
    cnt = 8'h00;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        step(1, cnt, 0, 1, {cnt + 8'd3, cnt + 8'd2, cnt + 8'd1, cnt}, 0);
        cnt = cnt + 8'd1;
      end
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 1);
    end

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) >= wp,
           $urandom_range(0, 99) < wp / 3, $urandom, $urandom_range(0, 99) >= wp);
    end

    // Asynchronous reset mid-operation at level 8.
    sync_rst();
    for (int i = 0; i < 8; i++) step(1, 8'(8'h70 + i), 0, (i < 2), 32'h0BADF00D, 0);
    chk("pre_arst_a_level", 32'(a_lvl), 8);
    chk("pre_arst_b_level", 32'(b_lvl), 8);
    #2 arst = 1;
    #1;
    chk("arst_a_level", 32'(a_lvl),   0);
    chk("arst_a_empty", 32'(a_empty), 1);
    chk("arst_a_full",  32'(a_full),  0);
    chk("arst_b_level", 32'(b_lvl),   0);
    chk("arst_b_empty", 32'(b_empty), 1);
    model_clear();
    @(negedge clk);
    arst = 0;
    @(negedge clk);
    step(1, 8'hA1, 0, 1, 32'h44332211, 0);
    step(1, 8'hA2, 0, 0, 0, 1);
    chk("post_arst_b_rd", 32'(b_rd), 32'h11);
    step(1, 8'hA3, 0, 0, 0, 0);
    step(1, 8'hA4, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("post_arst_a_rd", a_rd, 32'hA4A3A2A1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
